// File: rtl/mem_port_pkg.sv
// Shared constants and FSM encoding for the data-memory port controller.
package mem_port_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] IO_IN_ADDR  = 10'h3FE;
    localparam logic [ADDR_W-1:0] IO_OUT_ADDR = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_e;

    // Everything below the I/O window is backed by RAM.
    function automatic logic is_ram_addr(input logic [ADDR_W-1:0] addr);
        return addr < IO_IN_ADDR;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Processor-side load/store bus of the data-memory port.
interface mem_port_ctrl_if;
    import mem_port_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] ReadData;
    logic              Ready;

    modport master (
        output Addr, WriteData, MemRead, MemWrite,
        input  ReadData, Ready
    );

    modport slave (
        input  Addr, WriteData, MemRead, MemWrite,
        output ReadData, Ready
    );
endinterface

// File: rtl/mem_ram_1k.sv
// Single-port 1024x16 RAM: synchronous write, registered read, no reset,
// written so synthesis maps it onto a block RAM.
module mem_ram_1k
    import mem_port_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_q
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Data-memory port controller: owns the data RAM plus two memory-mapped I/O
// registers and stalls the processor through Ready while a load is in flight.
module mem_port_ctrl
    import mem_port_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset,
    mem_port_ctrl_if.slave     bus,
    input  logic [DATA_W-1:0]  IOIn,
    output logic [DATA_W-1:0]  IOOut,
    output logic               IOOutStrobe
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              strobe_q, strobe_d;
    logic [DATA_W-1:0] sync1_q, sync1_d;
    logic [DATA_W-1:0] sync2_q, sync2_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    mem_ram_1k u_ram (
        .clk     (CLK),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (bus.WriteData),
        .rdata_q (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        io_out_d = io_out_q;
        strobe_d = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        sync1_d  = IOIn;
        sync2_d  = sync1_q;

        case (state_q)
            IDLE: begin
                // The RAM sees the live address in IDLE so its registered
                // output is ready by the time the FSM sits in RD_WAIT.
                ram_addr = bus.Addr;
                if (bus.MemWrite) begin
                    if (is_ram_addr(bus.Addr)) begin
                        ram_we = 1'b1;
                    end else if (bus.Addr == IO_OUT_ADDR) begin
                        io_out_d = bus.WriteData;
                        strobe_d = 1'b1;
                    end
                end else if (bus.MemRead) begin
                    addr_d  = bus.Addr;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (addr_q == IO_IN_ADDR) begin
                    rdata_d = sync2_q;
                end else if (addr_q == IO_OUT_ADDR) begin
                    rdata_d = io_out_q;
                end else begin
                    rdata_d = ram_rdata;
                end
                state_d = RD_DONE;
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            io_out_q <= '0;
            strobe_q <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            io_out_q <= io_out_d;
            strobe_q <= strobe_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
    end

    assign bus.ReadData = rdata_q;
    assign bus.Ready    = (state_q != RD_WAIT);
    assign IOOut        = io_out_q;
    assign IOOutStrobe  = strobe_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: directed scenarios plus random traffic
// against an array-based model of the memory map.
module tb_mem_port_ctrl;
    import mem_port_pkg::*;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [DATA_W-1:0] IOIn;
    logic [DATA_W-1:0] IOOut;
    logic              IOOutStrobe;

    mem_port_ctrl_if bus();

    mem_port_ctrl dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .bus         (bus),
        .IOIn        (IOIn),
        .IOOut       (IOOut),
        .IOOutStrobe (IOOutStrobe)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mem_m [1024];
    logic [ADDR_W-1:0] written_q [$];
    logic [DATA_W-1:0] io_out_m;
    logic [DATA_W-1:0] io_in_m;

    bit rst_at_edge = 1'b1;
    bit prev_ready  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // A load completes when Ready rises again without a reset in between.
    always @(posedge CLK) rst_at_edge = Reset;

    always @(negedge CLK) begin
        logic [DATA_W-1:0] e;
        if (!rst_at_edge && !prev_ready && bus.Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got completion with %h, required none", bus.ReadData);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", bus.ReadData, e);
            end
        end
        prev_ready = (bus.Ready === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (a == IO_IN_ADDR)  return io_in_m;
        if (a == IO_OUT_ADDR) return io_out_m;
        return mem_m[a];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit also_read);
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = also_read;
        @(negedge CLK);
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        check("wr_ready", bus.Ready, 1);
        if (a == IO_OUT_ADDR) begin
            io_out_m = d;
            check("wr_strobe_on", IOOutStrobe, 1);
        end else begin
            check("wr_strobe_off", IOOutStrobe, 0);
            if (a < IO_IN_ADDR) begin
                mem_m[a] = d;
                written_q.push_back(a);
            end
        end
        check("wr_ioout", IOOut, io_out_m);
        @(negedge CLK);
        check("wr_strobe_pulse", IOOutStrobe, 0);
        check("wr_no_stall", bus.Ready, 1);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        bus.Addr     = a;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        exp_q.push_back(e);
        @(negedge CLK);
        bus.MemRead = 1'b0;
        check("rd_stall", bus.Ready, 0);
        @(negedge CLK);
        check("rd_done_ready", bus.Ready, 1);
        @(negedge CLK);
        check("rd_hold", bus.ReadData, e);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int op;

        Reset         = 1'b1;
        IOIn          = '0;
        bus.Addr      = '0;
        bus.WriteData = '0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        io_out_m      = '0;
        io_in_m       = '0;
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;

        idle(3);
        check("rst_ready", bus.Ready, 1);
        check("rst_rdata", bus.ReadData, 0);
        check("rst_ioout", IOOut, 0);
        check("rst_strobe", IOOutStrobe, 0);
        Reset = 1'b0;
        idle(2);
        check("idle_ready", bus.Ready, 1);
        check("idle_strobe", IOOutStrobe, 0);

        do_write(10'h005, 16'hBEEF, 1'b0);
        do_read(10'h005, 16'hBEEF);

        do_write(IO_OUT_ADDR, 16'h00A5, 1'b0);
        do_read(IO_OUT_ADDR, 16'h00A5);

        IOIn = 16'h1234;
        idle(3);
        io_in_m = 16'h1234;
        do_read(IO_IN_ADDR, 16'h1234);
        do_write(IO_IN_ADDR, 16'hFFFF, 1'b0);
        do_read(IO_IN_ADDR, 16'h1234);

        // A read issued in the same cycle IOIn changes still sees the old value.
        IOIn = 16'h5A5A;
        do_read(IO_IN_ADDR, 16'h1234);
        io_in_m = 16'h5A5A;
        do_read(IO_IN_ADDR, 16'h5A5A);

        do_write(10'h010, 16'h0042, 1'b1);
        do_read(10'h010, 16'h0042);

        do_write(10'h020, 16'h7777, 1'b0);
        bus.Addr    = 10'h020;
        bus.MemRead = 1'b1;
        @(negedge CLK);
        bus.MemRead = 1'b0;
        check("rstrd_stall", bus.Ready, 0);
        Reset = 1'b1;
        @(negedge CLK);
        Reset    = 1'b0;
        io_out_m = '0;
        check("rstrd_ready", bus.Ready, 1);
        check("rstrd_rdata", bus.ReadData, 0);
        check("rstrd_ioout", IOOut, 0);
        idle(1);
        check("rstrd_idle", bus.Ready, 1);
        do_read(10'h020, 16'h7777);

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    a = 10'($urandom_range(0, 10'h3FD));
                    d = 16'($urandom);
                    do_write(a, d, 1'($urandom_range(0, 1)));
                end
                2: begin
                    d = 16'($urandom);
                    do_write(IO_OUT_ADDR, d, 1'b0);
                end
                3: begin
                    a = written_q[$urandom_range(0, written_q.size() - 1)];
                    do_read(a, model_read(a));
                end
                4: begin
                    do_read(IO_OUT_ADDR, model_read(IO_OUT_ADDR));
                end
                default: begin
                    d    = 16'($urandom);
                    IOIn = d;
                    idle(3);
                    io_in_m = d;
                    do_read(IO_IN_ADDR, model_read(IO_IN_ADDR));
                end
            endcase
        end

        idle(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
